// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the instruction decode sequencer:
//   - opcode constants (top nibble of a 16-bit instruction)
//   - sequencer state encoding
//   - packed per-cycle control word (ctrl_t) and its all-zero NOP value
//   - helper that says whether an opcode counts as a retired instruction
// -----------------------------------------------------------------------------
package decode_pkg;

   localparam int OP_W      = 4;
   localparam int ALU_WIDTH = 4;
   localparam int RAD_WIDTH = 3;

   localparam logic [OP_W-1:0] OP_NOP   = 4'h0;
   localparam logic [OP_W-1:0] OP_ALU_L = 4'h1;  // first ALU opcode
   localparam logic [OP_W-1:0] OP_ALU_H = 4'h7;  // last ALU opcode
   localparam logic [OP_W-1:0] OP_IN    = 4'h8;
   localparam logic [OP_W-1:0] OP_LOAD  = 4'h9;
   localparam logic [OP_W-1:0] OP_STORE = 4'hA;
   localparam logic [OP_W-1:0] OP_JMP   = 4'hB;
   localparam logic [OP_W-1:0] OP_BEQZ  = 4'hC;
   localparam logic [OP_W-1:0] OP_ILL_D = 4'hD;
   localparam logic [OP_W-1:0] OP_ILL_E = 4'hE;
   localparam logic [OP_W-1:0] OP_HALT  = 4'hF;

   typedef enum logic [1:0] {
      ST_DISPATCH = 2'd0,
      ST_MEM2     = 2'd1,
      ST_BUBBLE   = 2'd2,
      ST_HALT     = 2'd3
   } state_e;

   // Field order is the order the downstream pipeline register lists them.
   // "in_sel" is the INPUT control (input is a reserved word).
   typedef struct packed {
      logic                 ar;
      logic                 br;
      logic [ALU_WIDTH-1:0] alu;
      logic                 in_sel;
      logic                 wren;
      logic [RAD_WIDTH-1:0] writead;
      logic                 adr_mux;
      logic                 write;
      logic                 pc_load;
   } ctrl_t;

   localparam int    CTRL_W   = $bits(ctrl_t);
   localparam ctrl_t CTRL_NOP = '0;

   // NOP is the only opcode that does not advance the retired counter;
   // illegal opcodes are still counted.
   function automatic logic is_counted(input logic [OP_W-1:0] op);
      return (op != OP_NOP);
   endfunction

endpackage

// File: rtl/instr_decode_rom.sv
// -----------------------------------------------------------------------------
// instr_decode_rom
// Purely combinational opcode decoder.
// Ports:
//   op_i       opcode field of the instruction
//   rd_i       destination register field
//   zero_i     ALU zero flag, decides BEQZ
//   ctrl_o     control word for the accept cycle
//   ctrl2_o    control word for the second cycle of LOAD/STORE (NOP otherwise)
//   next_o     state the sequencer moves to after the accept
//   illegal_o  opcode is one of the undefined ones
//   counted_o  instruction advances the retired counter
// -----------------------------------------------------------------------------
module instr_decode_rom
   import decode_pkg::*;
(
   input  logic [OP_W-1:0]      op_i,
   input  logic [RAD_WIDTH-1:0] rd_i,
   input  logic                 zero_i,
   output logic [CTRL_W-1:0]    ctrl_o,
   output logic [CTRL_W-1:0]    ctrl2_o,
   output logic [1:0]           next_o,
   output logic                 illegal_o,
   output logic                 counted_o
);

   ctrl_t  first_c;
   ctrl_t  second_c;
   state_e next_c;

   always_comb begin
      first_c   = CTRL_NOP;
      second_c  = CTRL_NOP;
      next_c    = ST_DISPATCH;
      illegal_o = 1'b0;

      case (op_i)
         OP_NOP: begin
         end
         OP_IN: begin
            first_c.in_sel  = 1'b1;
            first_c.write   = 1'b1;
            first_c.writead = rd_i;
         end
         OP_LOAD: begin
            first_c.ar       = 1'b1;
            first_c.adr_mux  = 1'b1;
            // rd travels with the second-cycle word so the top only has
            // to hold one registered word across the MEM2 state.
            second_c.adr_mux = 1'b1;
            second_c.write   = 1'b1;
            second_c.writead = rd_i;
            next_c           = ST_MEM2;
         end
         OP_STORE: begin
            first_c.ar       = 1'b1;
            first_c.br       = 1'b1;
            first_c.adr_mux  = 1'b1;
            second_c.adr_mux = 1'b1;
            second_c.wren    = 1'b1;
            next_c           = ST_MEM2;
         end
         OP_JMP: begin
            first_c.pc_load = 1'b1;
            next_c          = ST_BUBBLE;
         end
         OP_BEQZ: begin
            first_c.pc_load = zero_i;
            next_c          = zero_i ? ST_BUBBLE : ST_DISPATCH;
         end
         OP_ILL_D, OP_ILL_E: begin
            illegal_o = 1'b1;
         end
         OP_HALT: begin
            next_c = ST_HALT;
         end
         default: begin
            // Remaining opcodes are OP_ALU_L..OP_ALU_H: opcode is the ALU op.
            first_c.ar      = 1'b1;
            first_c.br      = 1'b1;
            first_c.alu     = op_i;
            first_c.write   = 1'b1;
            first_c.writead = rd_i;
         end
      endcase
   end

   assign ctrl_o    = first_c;
   assign ctrl2_o   = second_c;
   assign next_o    = next_c;
   assign counted_o = is_counted(op_i);

endmodule

// File: rtl/instr_decode_sequencer.sv
// -----------------------------------------------------------------------------
// instr_decode_sequencer
// Decode stage feeding the decode pipeline register. Accepts instructions over
// valid/ready, sequences two-cycle memory ops, inserts a bubble after taken
// branches and latches HALT. All control outputs are registered.
// Ports:
//   CLK, RST_N             clock (rising edge), asynchronous active-low reset
//   INSTR_IN/INSTR_VALID   instruction from fetch and its valid
//   INSTR_READY            accept this cycle (state DISPATCH and no STALL)
//   STALL                  downstream hazard, blocks acceptance
//   ZERO_IN                ALU zero flag for BEQZ
//   AR_OUT..PC_LOAD_OUT    registered control word
//   HALTED                 HALT has been executed
//   ILLEGAL                one-cycle pulse after accepting an illegal opcode
//   RETIRED                count of accepted non-NOP instructions
// -----------------------------------------------------------------------------
module instr_decode_sequencer
   import decode_pkg::*;
#(
   parameter int INSTR_W  = 16,
   parameter int ALU_W    = 4,
   parameter int REG_AD_W = 3,
   parameter int CNT_W    = 16
)(
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [INSTR_W-1:0]  INSTR_IN,
   input  logic                INSTR_VALID,
   output logic                INSTR_READY,
   input  logic                STALL,
   input  logic                ZERO_IN,
   output logic                AR_OUT,
   output logic                BR_OUT,
   output logic [ALU_W-1:0]    ALU_OUT,
   output logic                INPUT_OUT,
   output logic                WREN_OUT,
   output logic [REG_AD_W-1:0] WRITEAD_OUT,
   output logic                ADR_MUX_OUT,
   output logic                WRITE_OUT,
   output logic                PC_LOAD_OUT,
   output logic                HALTED,
   output logic                ILLEGAL,
   output logic [CNT_W-1:0]    RETIRED
);

   // Instruction fields
   logic [OP_W-1:0]      op_w;
   logic [RAD_WIDTH-1:0] rd_w;
   logic                 unused_imm;

   assign op_w       = INSTR_IN[INSTR_W-1 -: OP_W];
   assign rd_w       = INSTR_IN[11:9];
   assign unused_imm = ^INSTR_IN[8:0];

   // Decoder
   ctrl_t      rom_first;
   ctrl_t      rom_second;
   logic [1:0] rom_next;
   logic       rom_illegal;
   logic       rom_counted;

   instr_decode_rom u_rom (
      .op_i      (op_w),
      .rd_i      (rd_w),
      .zero_i    (ZERO_IN),
      .ctrl_o    (rom_first),
      .ctrl2_o   (rom_second),
      .next_o    (rom_next),
      .illegal_o (rom_illegal),
      .counted_o (rom_counted)
   );

   // State
   state_e           state_q,   state_d;
   ctrl_t            ctrl_q,    ctrl_d;
   ctrl_t            mem2_q,    mem2_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             accept;

   assign INSTR_READY = (state_q == ST_DISPATCH) && !STALL;
   assign accept      = INSTR_VALID && INSTR_READY;

   always_comb begin
      state_d   = state_q;
      ctrl_d    = CTRL_NOP;
      mem2_d    = mem2_q;
      illegal_d = 1'b0;
      retired_d = retired_q;

      case (state_q)
         ST_DISPATCH: begin
            if (accept) begin
               ctrl_d    = rom_first;
               mem2_d    = rom_second;
               state_d   = state_e'(rom_next);
               illegal_d = rom_illegal;
               if (rom_counted) begin
                  retired_d = retired_q + CNT_W'(1);
               end
            end
         end
         ST_MEM2: begin
            // Second half of LOAD/STORE; STALL is deliberately ignored.
            ctrl_d  = mem2_q;
            state_d = ST_DISPATCH;
         end
         ST_BUBBLE: begin
            state_d = ST_DISPATCH;
         end
         ST_HALT: begin
            // Terminal: only reset leaves this state.
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_DISPATCH;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_DISPATCH;
         ctrl_q    <= CTRL_NOP;
         mem2_q    <= CTRL_NOP;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         mem2_q    <= mem2_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

   assign AR_OUT      = ctrl_q.ar;
   assign BR_OUT      = ctrl_q.br;
   assign ALU_OUT     = ctrl_q.alu;
   assign INPUT_OUT   = ctrl_q.in_sel;
   assign WREN_OUT    = ctrl_q.wren;
   assign WRITEAD_OUT = ctrl_q.writead;
   assign ADR_MUX_OUT = ctrl_q.adr_mux;
   assign WRITE_OUT   = ctrl_q.write;
   assign PC_LOAD_OUT = ctrl_q.pc_load;
   assign HALTED      = (state_q == ST_HALT);
   assign ILLEGAL     = illegal_q;
   assign RETIRED     = retired_q;

endmodule

// File: doc/instr_decode_sequencer.md
Name: instr_decode_sequencer

Overview:
- Decode stage that sits directly upstream of the decode pipeline register; converts 16-bit instructions into the per-cycle control word (AR, BR, ALU, INPUT, WREN, WRITEAD, ADR_MUX, WRITE, PC_LOAD) that the register captures.
- Accepts instructions from fetch over a valid/ready handshake and sequences the two-cycle memory ops.
- Inserts a bubble after taken branches and latches HALT.
- All control outputs are registered, so the downstream register sees stable values one full cycle after acceptance.

Parameters:
INSTR_W, 16, instruction width
ALU_W, 4, ALU opcode width
REG_AD_W, 3, register-file address width
CNT_W, 16, retired-instruction counter width

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
INSTR_IN  in  INSTR_W  instruction from fetch: [15:12] op, [11:9] rd, [8:6] rs, [5:0] imm
INSTR_VALID  in  1  INSTR_IN valid
INSTR_READY  out  1  decoder accepts INSTR_IN this cycle
STALL  in  1  downstream hazard; blocks acceptance
ZERO_IN  in  1  ALU zero flag for BEQZ
AR_OUT  out  1  load A operand register
BR_OUT  out  1  load B operand register
ALU_OUT  out  ALU_W  ALU operation
INPUT_OUT  out  1  select external input onto write bus
WREN_OUT  out  1  data-memory write enable
WRITEAD_OUT  out  REG_AD_W  register-file write address
ADR_MUX_OUT  out  1  memory address from A register (1) / PC (0)
WRITE_OUT  out  1  register-file write enable
PC_LOAD_OUT  out  1  load PC (branch taken)
HALTED  out  1  HALT executed
ILLEGAL  out  1  one-cycle pulse, illegal opcode accepted
RETIRED  out  CNT_W  count of accepted non-NOP instructions

Behaviour:
- Reset: all control outputs 0, HALTED=0, ILLEGAL=0, RETIRED=0, state=DISPATCH. Reset is asynchronous and overrides everything, including a mid-sequence MEM2 state: the pending second cycle is dropped.
- States: DISPATCH, MEM2, BUBBLE, HALT_ST.
- INSTR_READY = (state==DISPATCH) && !STALL. This is combinational from state and STALL only, never from INSTR_VALID.
- Accept = INSTR_VALID && INSTR_READY.
- Any cycle without an accept, outside MEM2, drives the NOP control word (all zero) on the next edge.
- Latency: control word is registered on the edge that completes the accept. It is visible for exactly one cycle.
- Decode on accept:
  - 0x0 NOP: all zero; not counted.
  - 0x1–0x7 ALU: AR=BR=1, ALU=op, WRITE=1, WRITEAD=rd.
  - 0x8 IN: INPUT=1, WRITE=1, WRITEAD=rd.
  - 0x9 LOAD: cycle 1 AR=1, ADR_MUX=1; go to MEM2. Cycle 2 ADR_MUX=1, WRITE=1, WRITEAD=rd (rd held internally).
  - 0xA STORE: cycle 1 AR=BR=1, ADR_MUX=1; go to MEM2. Cycle 2 ADR_MUX=1, WREN=1.
  - 0xB JMP: PC_LOAD=1; go to BUBBLE.
  - 0xC BEQZ: PC_LOAD=ZERO_IN, sampled in the accept cycle. If taken, go to BUBBLE; else stay in DISPATCH.
  - 0xF HALT: all zero; go to HALT_ST; HALTED=1.
  - 0xD/0xE: NOP word, ILLEGAL pulses 1 cycle, counted.
- ALU field is 0 for every op except 0x1–0x7.
- MEM2 and BUBBLE last exactly one cycle each, ignore STALL, then return to DISPATCH. BUBBLE emits the NOP word.
- HALT_ST: INSTR_READY=0 and the NOP word is emitted forever; only RST_N exits.
- RETIRED increments on the accept edge and wraps modulo 2^CNT_W.
- STALL rising while INSTR_VALID is high: no accept; INSTR_IN must be held by fetch (standard valid/ready).

Decomposition:
- Shared package decode_pkg holds:
  - opcode constants OP_NOP…OP_HALT;
  - state encoding;
  - a packed control-word struct (ar, br, alu, input, wren, writead, adr_mux, write, pc_load) with a CTRL_NOP constant.
- One combinational sub-module, instr_decode_rom, maps op/rd/ZERO_IN to the first-cycle control word plus a next-state hint. The sequencer FSM, output register and counter stay in the top.

Test Plan:
- Reset mid-LOAD: accept 0x9A40 (LOAD rd=5), assert RST_N=0 in the MEM2 cycle -> all outputs 0 immediately, state DISPATCH, no WRITE pulse.
- ALU back-to-back: 0x3A40 then 0x1200, VALID constant -> two consecutive cycles with ALU=3,WRITEAD=5 then ALU=1,WRITEAD=1. AR=BR=WRITE=1 both cycles. INSTR_READY stays 1. RETIRED=2.
- STORE: 0xA0C0 -> cycle 1 AR=BR=ADR_MUX=1, WREN=0. Cycle 2 ADR_MUX=1, WREN=1. INSTR_READY=0 during the MEM2 cycle.
- BEQZ: 0xC000 with ZERO_IN=1 -> PC_LOAD=1 for one cycle, then a NOP bubble with READY=0. Repeat with ZERO_IN=0 -> PC_LOAD=0, no bubble.
- STALL: hold VALID=1 with 0x2200, STALL=1 for 3 cycles -> READY=0 and NOP words for 3 cycles. Then STALL=0 -> single accept, ALU=2 once.
- HALT/illegal: 0xD000 -> ILLEGAL pulse 1 cycle. Then 0xF000 -> HALTED=1 and READY=0 permanently despite VALID=1. RETIRED=2 until reset.
